// File: rtl/mem_ctrl_seq.sv
// rtl/mem_ctrl_seq.sv - byte-serial memory port responder for IF fetches and MEM loads/stores
// MEM wins arbitration; reads are captured one cycle behind issue and reassembled little-endian.
module mem_ctrl_seq #(
  parameter int RAM_ADDR_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_abort_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic        busy_o
);

  localparam logic [31:0] ADDR_MASK = (RAM_ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << RAM_ADDR_WIDTH) - 32'd1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  logic        owner_mem;
  logic        we;
  logic [2:0]  n;
  logic [1:0]  k;
  logic [1:0]  c;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] result;

  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic [2:0]  acc_n;
  logic        last;
  logic        if_aborted;
  logic [31:0] next_addr;
  logic [31:0] read_mask;
  logic [31:0] final_word;

  assign acc_addr   = mem_req_i ? mem_addr_i : if_addr_i;
  assign acc_wdata  = mem_req_i ? mem_wdata_i : 32'd0;
  assign acc_we     = mem_req_i & mem_we_i;
  assign acc_n      = !mem_req_i ? 3'd4 : (mem_len_i == 2'd0) ? 3'd1
                    : (mem_len_i == 2'd1) ? 3'd2 : 3'd4;
  assign last       = ({1'b0, k} == (n - 3'd1));
  assign if_aborted = if_abort_i & ~owner_mem;
  assign next_addr  = (base + {30'd0, k} + 32'd1) & ADDR_MASK;
  assign read_mask  = (n == 3'd1) ? 32'h0000_00FF : (n == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  // The final byte is merged combinationally so DONE can present the full word.
  assign final_word = (result | ({24'd0, ram_din_i} << {c, 3'b000})) & read_mask;
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_mem   <= 1'b0;
      we          <= 1'b0;
      n           <= 3'd0;
      k           <= 2'd0;
      c           <= 2'd0;
      base        <= 32'd0;
      wdata       <= 32'd0;
      result      <= 32'd0;
      if_data_o   <= 32'd0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= 32'd0;
      mem_done_o  <= 1'b0;
      ram_addr_o  <= 32'd0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          ram_wr_o <= 1'b0;
          if (mem_req_i || if_req_i) begin
            owner_mem  <= mem_req_i;
            we         <= acc_we;
            n          <= acc_n;
            base       <= acc_addr;
            wdata      <= acc_wdata;
            k          <= 2'd0;
            c          <= 2'd0;
            result     <= 32'd0;
            ram_addr_o <= acc_addr & ADDR_MASK;
            ram_wr_o   <= acc_we;
            ram_dout_o <= acc_wdata[7:0];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (if_aborted) begin
            ram_wr_o <= 1'b0;
            state    <= IDLE;
          end else begin
            if (!we && k != 2'd0) begin
              result[{c, 3'b000} +: 8] <= ram_din_i;
              c <= c + 2'd1;
            end
            if (last) begin
              ram_wr_o <= 1'b0;
              if (we) begin
                mem_done_o <= 1'b1;
                state      <= DONE;
              end else begin
                state <= DRAIN;
              end
            end else begin
              k          <= k + 2'd1;
              ram_addr_o <= next_addr;
              ram_dout_o <= wdata[{k + 2'd1, 3'b000} +: 8];
            end
          end
        end
        DRAIN: begin
          ram_wr_o <= 1'b0;
          if (if_aborted) begin
            state <= IDLE;
          end else begin
            state <= DONE;
            if (owner_mem) begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= final_word;
            end else begin
              if_done_o <= 1'b1;
              if_data_o <= final_word;
            end
          end
        end
        DONE: begin
          ram_wr_o   <= 1'b0;
          if_done_o  <= 1'b0;
          mem_done_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// tb/tb_mem_ctrl_seq.sv - scoreboard bench for mem_ctrl_seq with a registered byte RAM model
module tb_mem_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
  logic        if_done_o, mem_done_o, ram_wr_o, busy_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  mem_ctrl_seq #(.RAM_ADDR_WIDTH(18)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_abort_i(if_abort),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:(1<<18)-1];
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o[17:0]] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o[17:0]];
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (if_done_o) begin
        if (if_q.size() == 0) begin
          total_cnt++;
          $display("FAIL if_done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          e = if_q.pop_front();
          check("if_done_cycle", 32'(cyc), 32'(e.cyc));
          check("if_data", if_data_o, e.data);
        end
      end
      if (mem_done_o) begin
        if (mem_q.size() == 0) begin
          total_cnt++;
          $display("FAIL mem_done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          e = mem_q.pop_front();
          check("mem_done_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk) check("mem_rdata", mem_rdata_o, e.data);
        end
      end
    end
  end

  task automatic run_access(input bit m, input bit we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, input string tag);
    int n, t0;
    bit seen;
    exp_t e;
    n  = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    t0 = cyc;
    e.data = exp;
    e.chk  = !we;
    e.cyc  = t0 + (we ? n + 1 : n + 2);
    if (m) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      mem_q.push_back(e);
    end else begin
      if_req = 1'b1; if_addr = addr;
      if_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_addr"}, ram_addr_o, (addr + 32'(i)) & 32'h3FFFF);
      check({tag, "_wr"}, {31'd0, ram_wr_o}, {31'd0, we});
      if (we) check({tag, "_dout"}, {24'd0, ram_dout_o}, {24'd0, wdata[8*i +: 8]});
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (m ? mem_done_o : if_done_o) begin
        seen = 1'b1;
        check({tag, "_wr_at_done"}, {31'd0, ram_wr_o}, 32'd0);
      end
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL %s_timeout: got no done expected done by cycle %0d", tag, e.cyc);
    end
    mem_req = 1'b0;
    if_req  = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int t0;
    bit seen;
    exp_t e;
    rst = 1'b1; if_req = 1'b0; if_abort = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    for (int i = 0; i < (1<<18); i++) ram[i] = 8'h00;
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05; ram[18'h00102] = 8'h10; ram[18'h00103] = 8'h00;
    ram[18'h02000] = 8'hFF;
    ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22; ram[18'h00000] = 8'h33; ram[18'h00001] = 8'h44;
    repeat (3) @(negedge clk);
    check("rst_if_data", if_data_o, 32'd0);
    check("rst_mem_rdata", mem_rdata_o, 32'd0);
    check("rst_ram_addr", ram_addr_o, 32'd0);
    check("rst_ctrl", {26'd0, if_done_o, mem_done_o, ram_wr_o, busy_o, 2'd0}, 32'd0);
    check("rst_dout", {24'd0, ram_dout_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access(1'b0, 1'b0, 2'b10, 32'h100, 32'd0, 32'h00100513, "fetch");

    // Simultaneous requests: MEM byte load first, IF fetch accepted in the IDLE after MEM's DONE.
    t0 = cyc;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h100;
    e.chk = 1'b1;
    e.data = 32'h000000FF; e.cyc = t0 + 3;  mem_q.push_back(e);
    e.data = 32'h00100513; e.cyc = t0 + 10; if_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_done_o) mem_req = 1'b0;
      if (if_done_o) begin if_req = 1'b0; seen = 1'b1; end
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL collide_timeout: got no if_done expected cycle %0d", t0 + 10);
    end
    mem_req = 1'b0; if_req = 1'b0;
    @(negedge clk);

    run_access(1'b1, 1'b1, 2'b01, 32'h2000, 32'h1234ABCD, 32'd0, "st_half");
    run_access(1'b0, 1'b0, 2'b10, 32'h3FFFE, 32'd0, 32'h44332211, "wrap");
    run_access(1'b1, 1'b0, 2'b01, 32'h2000, 32'd0, 32'h0000ABCD, "ld_half");
    run_access(1'b1, 1'b0, 2'b11, 32'h2000, 32'd0, 32'h0000ABCD, "ld_word");
    run_access(1'b1, 1'b0, 2'b00, 32'h2001, 32'd0, 32'h000000AB, "ld_byte");

    // Abort in cycle 3 with the request still held: re-accepted in cycle 4, done in cycle 10.
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk);
    if_abort = 1'b1;
    e.chk = 1'b1; e.data = 32'h00100513; e.cyc = t0 + 10; if_q.push_back(e);
    @(negedge clk);
    if_abort = 1'b0;
    check("abort_idle_busy", {31'd0, busy_o}, 32'd0);
    check("abort_if_data_held", if_data_o, 32'h44332211);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (if_done_o) seen = 1'b1;
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL abort_refetch_timeout: got no if_done expected cycle %0d", t0 + 10);
    end
    if_req = 1'b0;
    @(negedge clk);

    // Reset in cycle 2 of a word store: bytes 0,1 written, bytes 2,3 never written.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    check("rstmid_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rstmid_addr", ram_addr_o, 32'd0);
    check("rstmid_if_data", if_data_o, 32'd0);
    check("rstmid_mem_rdata", mem_rdata_o, 32'd0);
    check("rstmid_ctrl", {28'd0, if_done_o, mem_done_o, busy_o, 1'b0}, 32'd0);
    @(negedge clk);
    check("rstmid_ram0", {24'd0, ram[18'h03000]}, 32'h000000EF);
    check("rstmid_ram1", {24'd0, ram[18'h03001]}, 32'h000000BE);
    check("rstmid_ram2", {24'd0, ram[18'h03002]}, 32'h00000000);
    run_access(1'b1, 1'b0, 2'b00, 32'h3001, 32'd0, 32'h000000BE, "ld_after_rst");

    repeat (4) @(negedge clk);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
